line_rasterizer: RTL and testbench
==================================

Name: line_rasterizer

Overview:
Bresenham line generator that walks from (X0,Y0) to (X1,Y1) and emits one pixel write per step to the framebuffer write port. It is the producer side of the line datapath. The per-pixel VGA-scan line test answers "is this pixel on the line?". This block answers "which pixels are on the line?" and pushes them out with a valid/ready handshake. It uses integer arithmetic only, covers all octants, and clips to the screen.

Parameters:
H_RES, 320, visible width; pixels with X outside 0..H_RES-1 are not emitted
V_RES, 240, visible height; pixels with Y outside 0..V_RES-1 are not emitted
COORD_W, 9, signed coordinate width
RGB_W, 12, colour width

Ports:
VGA_CLK  in  1  single clock, rising edge
RST_N  in  1  asynchronous active-low reset
START  in  1  one-cycle request; accepted only in IDLE
X0, Y0, X1, Y1  in  COORD_W signed  endpoints, sampled when START is accepted
COLOR  in  RGB_W  line colour, sampled with the endpoints
PIX_X, PIX_Y  out  COORD_W signed  current pixel coordinate
PIX_RGB  out  RGB_W  latched colour
PIX_VALID  out  1  pixel write request
PIX_READY  in  1  framebuffer accepts the pixel when PIX_VALID and PIX_READY are both high at a clock edge
BUSY  out  1  high from the START-accept cycle until DONE
DONE  out  1  one-cycle pulse after the last pixel

Behaviour:
- Reset (asynchronous, RST_N=0): state goes to IDLE. PIX_X, PIX_Y, PIX_RGB, PIX_VALID, BUSY and DONE all go to 0. Reset mid-line aborts the line immediately; no DONE is produced.
- States: IDLE, SETUP, STEP, FINISH.
- IDLE: when START=1 at an edge, latch the endpoints and COLOR, set BUSY=1, and go to SETUP. START in any other state is ignored.
- SETUP (1 cycle):
  - dx = |X1-X0|, dy = -|Y1-Y0|
  - sx = +1 if X0<X1, else -1; sy = +1 if Y0<Y1, else -1
  - err = dx+dy; cur = (X0,Y0)
  - Widths: dx and dy are 11-bit signed; err is 12-bit signed; e2 = 2*err is 13-bit signed. There is no overflow for any 9-bit endpoint pair.
- STEP:
  - PIX_X/PIX_Y = cur; PIX_VALID = 1 if cur is on screen, else 0.
  - The pixel "retires" on a handshake if it is on screen, or unconditionally after one cycle if it is off screen.
  - While PIX_VALID=1 and PIX_READY=0, PIX_X, PIX_Y and PIX_RGB must hold stable. PIX_VALID must not drop until the handshake.
- On retire:
  - If cur == (X1,Y1), go to FINISH.
  - Otherwise, with e2 = 2*err: if e2 >= dy, then err += dy and x += sx. If e2 <= dx, then err += dx and y += sy. Both updates may apply in the same step, and the err deltas sum.
- Throughput: one pixel per cycle with PIX_READY held high. First PIX_VALID occurs 2 cycles after the START edge.
- Total pixels walked = max(dx,|dy|)+1, clipped ones included.
- FINISH: PIX_VALID=0, DONE=1 for exactly one cycle, BUSY=0 in the same cycle, then return to IDLE. START in FINISH is ignored.
- Degenerate line (X0,Y0)==(X1,Y1): exactly one pixel, then FINISH.
- Fully off-screen line: no PIX_VALID at all; DONE still pulses after max(dx,|dy|)+1 STEP cycles.
- PIX_RGB = latched COLOR from the accept cycle until the next START is accepted.

Test Plan:
- Horizontal (0,0)->(3,0), COLOR=12'hF00, PIX_READY=1 -> pixels (0,0),(1,0),(2,0),(3,0) on 4 consecutive cycles starting 2 cycles after START; PIX_RGB=F00; DONE 1 cycle later; BUSY drops with DONE.
- Steep negative (2,5)->(0,0) -> exact order (2,5),(2,4),(1,3),(1,2),(0,1),(0,0), then DONE.
- Backpressure on (0,0)->(2,2): hold PIX_READY=0 for 3 cycles on pixel (1,1) -> PIX_VALID stays 1 and PIX_X/PIX_Y stay at (1,1); sequence completes with (2,2) after release.
- Clipping (-2,0)->(1,0) -> only (0,0),(1,0) are emitted; 4 STEP cycles; DONE pulses. A second START asserted during BUSY is ignored, with no extra pixels.
- Degenerate (7,7)->(7,7) -> single pixel (7,7), then DONE.
- Reset mid-line: assert RST_N=0 asynchronously during the 3rd pixel of (0,0)->(10,0) -> all outputs go to 0 immediately and no DONE occurs. After release, a new START for (5,5)->(6,5) produces (5,5),(6,5) correctly.

Source files
------------

// File: rtl/line_rasterizer_if.sv
// line_rasterizer_if: command/pixel-write bundle between a line requester and the rasterizer.
interface line_rasterizer_if #(
  parameter int COORD_W = 9,
  parameter int RGB_W   = 12
);
  logic                      START;
  logic signed [COORD_W-1:0] X0, Y0, X1, Y1;
  logic        [RGB_W-1:0]   COLOR;
  logic signed [COORD_W-1:0] PIX_X, PIX_Y;
  logic        [RGB_W-1:0]   PIX_RGB;
  logic                      PIX_VALID;
  logic                      PIX_READY;
  logic                      BUSY;
  logic                      DONE;
  modport master (
    output START, X0, Y0, X1, Y1, COLOR, PIX_READY,
    input  PIX_X, PIX_Y, PIX_RGB, PIX_VALID, BUSY, DONE
  );
  modport slave (
    input  START, X0, Y0, X1, Y1, COLOR, PIX_READY,
    output PIX_X, PIX_Y, PIX_RGB, PIX_VALID, BUSY, DONE
  );
endinterface

// File: rtl/line_rasterizer.sv
// line_rasterizer: Bresenham walker emitting on-screen pixels of a line over a valid/ready write port.
module line_rasterizer #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COORD_W = 9,
  parameter int RGB_W   = 12
) (
  input logic         VGA_CLK,
  input logic         RST_N,
  line_rasterizer_if.slave bus
);
  localparam int D_W = COORD_W + 2;
  localparam int E_W = COORD_W + 3;
  typedef enum logic [1:0] {IDLE, SETUP, STEP, FINISH} state_t;
  state_t state, state_n;
  logic signed [COORD_W-1:0] x0, y0, x1, y1, cx, cy, sx, sy;
  logic signed [D_W-1:0]     dx, dy, ddx, ddy, adx, ady;
  logic signed [E_W-1:0]     err, err_n;
  logic signed [E_W:0]       e2;
  logic [RGB_W-1:0]          rgb;
  logic                      on_scr, retire, at_end, step_x, step_y;
  always_comb begin
    ddx    = $signed({{2{x1[COORD_W-1]}}, x1}) - $signed({{2{x0[COORD_W-1]}}, x0});
    ddy    = $signed({{2{y1[COORD_W-1]}}, y1}) - $signed({{2{y0[COORD_W-1]}}, y0});
    adx    = ddx < 0 ? -ddx : ddx;
    ady    = ddy < 0 ? -ddy : ddy;
    on_scr = int'(cx) >= 0 && int'(cx) < H_RES && int'(cy) >= 0 && int'(cy) < V_RES;
    retire = !on_scr || bus.PIX_READY;
    at_end = cx == x1 && cy == y1;
    e2     = {err, 1'b0};
    step_x = e2 >= dy;
    step_y = e2 <= dx;
    err_n  = err + (step_x ? E_W'(dy) : E_W'(0)) + (step_y ? E_W'(dx) : E_W'(0));
  end
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus.START ? SETUP : IDLE;
      SETUP:   state_n = STEP;
      STEP:    state_n = retire && at_end ? FINISH : STEP;
      default: state_n = IDLE;
    endcase
  end
  assign bus.PIX_X     = cx;
  assign bus.PIX_Y     = cy;
  assign bus.PIX_RGB   = rgb;
  assign bus.PIX_VALID = state == STEP && on_scr;
  assign bus.BUSY      = state == SETUP || state == STEP;
  assign bus.DONE      = state == FINISH;
  always_ff @(posedge VGA_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state <= IDLE;
      {x0, y0, x1, y1, cx, cy, sx, sy} <= '0;
      {dx, dy} <= '0;
      err <= '0;
      rgb <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && bus.START) begin
        x0  <= bus.X0;
        y0  <= bus.Y0;
        x1  <= bus.X1;
        y1  <= bus.Y1;
        cx  <= bus.X0;
        cy  <= bus.Y0;
        rgb <= bus.COLOR;
      end
      if (state == SETUP) begin
        dx  <= adx;
        dy  <= -ady;
        sx  <= x0 < x1 ? COORD_W'(1) : '1;
        sy  <= y0 < y1 ? COORD_W'(1) : '1;
        err <= E_W'(adx) - E_W'(ady);
      end
      if (state == STEP && retire && !at_end) begin
        err <= err_n;
        if (step_x) cx <= cx + sx;
        if (step_y) cy <= cy + sy;
      end
    end
  end
endmodule

// File: tb/tb_line_rasterizer.sv
// tb_line_rasterizer: directed Bresenham vectors with hand-computed pixel sequences.
module tb_line_rasterizer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  line_rasterizer_if #(.COORD_W(9), .RGB_W(12)) bus();
  line_rasterizer #(.H_RES(320), .V_RES(240), .COORD_W(9), .RGB_W(12)) dut (
    .VGA_CLK(clk),
    .RST_N(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic launch(input int ax, input int ay, input int bx, input int by, input logic [11:0] c);
    bus.X0 = 9'(ax);
    bus.Y0 = 9'(ay);
    bus.X1 = 9'(bx);
    bus.Y1 = 9'(by);
    bus.COLOR = c;
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    chk("setup_busy", 32'(bus.BUSY), 1);
    chk("setup_valid", 32'(bus.PIX_VALID), 0);
  endtask
  task automatic pix(input string tag, input int x, input int y);
    @(negedge clk);
    chk({tag, ".valid"}, 32'(bus.PIX_VALID), 1);
    chk({tag, ".x"}, bus.PIX_X, x);
    chk({tag, ".y"}, bus.PIX_Y, y);
  endtask
  task automatic fin(input string tag);
    @(negedge clk);
    chk({tag, ".done"}, 32'(bus.DONE), 1);
    chk({tag, ".busy"}, 32'(bus.BUSY), 0);
    chk({tag, ".valid"}, 32'(bus.PIX_VALID), 0);
    @(negedge clk);
    chk({tag, ".done_pulse"}, 32'(bus.DONE), 0);
  endtask
  initial begin
    bus.START = 1'b0;
    bus.PIX_READY = 1'b1;
    bus.X0 = '0; bus.Y0 = '0; bus.X1 = '0; bus.Y1 = '0;
    bus.COLOR = '0;
    repeat (2) @(negedge clk);
    chk("rst.valid", 32'(bus.PIX_VALID), 0);
    chk("rst.busy", 32'(bus.BUSY), 0);
    chk("rst.done", 32'(bus.DONE), 0);
    chk("rst.rgb", 32'(bus.PIX_RGB), 0);
    rst_n = 1'b1;
    @(negedge clk);
    // horizontal
    launch(0, 0, 3, 0, 12'hF00);
    pix("h0", 0, 0);
    chk("h0.rgb", 32'(bus.PIX_RGB), 32'h F00);
    pix("h1", 1, 0);
    pix("h2", 2, 0);
    pix("h3", 3, 0);
    fin("h");
    // steep negative
    launch(2, 5, 0, 0, 12'h0AB);
    pix("s0", 2, 5);
    pix("s1", 2, 4);
    pix("s2", 1, 3);
    pix("s3", 1, 2);
    pix("s4", 0, 1);
    pix("s5", 0, 0);
    chk("s5.rgb", 32'(bus.PIX_RGB), 32'h0AB);
    fin("s");
    // backpressure on the middle pixel
    launch(0, 0, 2, 2, 12'h0F0);
    pix("b0", 0, 0);
    pix("b1", 1, 1);
    bus.PIX_READY = 1'b0;
    for (int i = 0; i < 3; i++) pix("b1_hold", 1, 1);
    bus.PIX_READY = 1'b1;
    pix("b2", 2, 2);
    fin("b");
    // clipping plus ignored START while busy
    launch(-2, 0, 1, 0, 12'h00F);
    @(negedge clk);
    chk("c0.valid", 32'(bus.PIX_VALID), 0);
    chk("c0.x", bus.PIX_X, -2);
    bus.X0 = 9'(50); bus.Y0 = 9'(50); bus.X1 = 9'(60); bus.Y1 = 9'(50);
    bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0;
    chk("c1.valid", 32'(bus.PIX_VALID), 0);
    chk("c1.x", bus.PIX_X, -1);
    pix("c2", 0, 0);
    pix("c3", 1, 0);
    chk("c3.rgb", 32'(bus.PIX_RGB), 32'h00F);
    fin("c");
    chk("c.idle_busy", 32'(bus.BUSY), 0);
    chk("c.idle_valid", 32'(bus.PIX_VALID), 0);
    // degenerate
    launch(7, 7, 7, 7, 12'h555);
    pix("d0", 7, 7);
    fin("d");
    // asynchronous reset mid-line
    launch(0, 0, 10, 0, 12'hFFF);
    pix("r0", 0, 0);
    pix("r1", 1, 0);
    pix("r2", 2, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("r.valid", 32'(bus.PIX_VALID), 0);
    chk("r.busy", 32'(bus.BUSY), 0);
    chk("r.done", 32'(bus.DONE), 0);
    chk("r.x", bus.PIX_X, 0);
    chk("r.y", bus.PIX_Y, 0);
    chk("r.rgb", 32'(bus.PIX_RGB), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("r.no_done", 32'(bus.DONE), 0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("r.after_done", 32'(bus.DONE), 0);
    launch(5, 5, 6, 5, 12'h123);
    pix("n0", 5, 5);
    pix("n1", 6, 5);
    chk("n1.rgb", 32'(bus.PIX_RGB), 32'h123);
    fin("n");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
